// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding
// and the filler instruction returned while fetch is not served from RAM.
package imem_pkg;

    typedef enum logic [2:0] {
        RUN,
        COLLECT,
        WRITE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: first accepted byte lands in [7:0],
// lanes not yet filled stay zero until the next clear.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] lane;

    // Asserted while the byte being accepted completes the word.
    assign full = accept && (lane == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane <= 2'd0;
            word <= '0;
        end else if (accept) begin
            word[{lane, 3'b000} +: 8] <= data;
            lane <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the imem_ram port between CPU fetch and a byte-stream loader.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running byte sum and ld_csum.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_hold,
    output logic              cpu_rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_error,
    output logic [ADDR_W:0]   ld_words,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [7:0]        ld_csum,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    state_t          state;
    logic [ADDR_W:0] word_ptr;
    logic            last_seen;
    logic            accept;
    logic            clear;
    logic            full;
    logic [31:0]     word;
    logic            csum_bad;
    logic            cpu_oob;
    logic            unused_ok;

    assign unused_ok = &{1'b0, cpu_addr[1:0]};

    assign accept = (state == COLLECT) && ld_valid && ld_ready;
    assign clear  = ((state == RUN) && ld_start) || (state == WRITE);

    imem_word_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .accept (accept),
        .data   (ld_data),
        .word   (word),
        .full   (full)
    );

    assign cpu_oob   = cpu_addr[31:ADDR_W+2] != '0;
    assign cpu_instr = (state == RUN && !cpu_oob) ? mem_rd : NOP_INSTR;
    assign mem_addr  = (state == RUN) ? cpu_addr[ADDR_W+1:2]
                                      : word_ptr[ADDR_W-1:0];
    assign mem_wd    = word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // DRAIN bytes count too, so the sum covers the whole stream sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (state == RUN && ld_start) begin
            csum <= 8'd0;
        end else if (ld_valid && ld_ready) begin
            csum <= csum + ld_data;
        end
    end

    assign ld_csum  = csum;
    assign csum_bad = csum != 8'd0;
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cpu_hold  <= 1'b0;
            cpu_rst   <= 1'b0;
            ld_ready  <= 1'b0;
            ld_done   <= 1'b0;
            ld_error  <= 1'b0;
            ld_words  <= '0;
            mem_we    <= 1'b0;
            word_ptr  <= '0;
            last_seen <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ld_start) begin
                        state     <= COLLECT;
                        cpu_hold  <= 1'b1;
                        ld_ready  <= 1'b1;
                        word_ptr  <= '0;
                        last_seen <= 1'b0;
                        ld_error  <= 1'b0;
                        ld_words  <= '0;
                    end
                end
                COLLECT: begin
                    if (accept && (full || ld_last)) begin
                        state     <= WRITE;
                        ld_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        last_seen <= ld_last;
                    end
                end
                WRITE: begin
                    mem_we   <= 1'b0;
                    word_ptr <= word_ptr + PTR_ONE;
                    if (last_seen) begin
                        state   <= DONE;
                        ld_done <= 1'b1;
                        cpu_rst <= 1'b1;
                    end else if (word_ptr == LAST_PTR) begin
                        state    <= DRAIN;
                        ld_error <= 1'b1;
                        ld_ready <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        ld_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (ld_valid && ld_last) begin
                        state    <= DONE;
                        ld_ready <= 1'b0;
                        ld_done  <= 1'b1;
                        cpu_rst  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= RUN;
                    ld_done  <= 1'b0;
                    cpu_rst  <= 1'b0;
                    cpu_hold <= 1'b0;
                    ld_words <= word_ptr;
                    if (csum_bad) begin
                        ld_error <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a DEPTH=128 instance for load/fetch
// behaviour and a DEPTH=4 instance for the overflow/drain path.
module tb_imem_load_ctrl;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic [31:0] instr_a, wd_a, rd_a;
    logic        hold_a, rst_a, ready_a, done_a, error_a, we_a;
    logic [7:0]  words_a;
    logic [6:0]  addr_a;
    logic [7:0]  csum_a;

    logic [31:0] instr_b, wd_b, rd_b;
    logic        hold_b, rst_b, ready_b, done_b, error_b, we_b;
    logic [2:0]  words_b;
    logic [1:0]  addr_b;
    logic [7:0]  csum_b;

    logic [31:0] ram_a [128];
    logic [31:0] ram_b [4];
    int          wr_a = 0;
    int          wr_b = 0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  bsum = '0;

    imem_load_ctrl #(.DEPTH(128)) u_dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_instr(instr_a),
        .cpu_hold(hold_a), .cpu_rst(rst_a), .ld_start(start_a),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ready_a), .ld_done(done_a), .ld_error(error_a),
        .ld_words(words_a),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .ld_csum(csum_a),
`endif
        .mem_addr(addr_a), .mem_we(we_a), .mem_wd(wd_a), .mem_rd(rd_a)
    );

    imem_load_ctrl #(.DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_instr(instr_b),
        .cpu_hold(hold_b), .cpu_rst(rst_b), .ld_start(start_b),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ready_b), .ld_done(done_b), .ld_error(error_b),
        .ld_words(words_b),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .ld_csum(csum_b),
`endif
        .mem_addr(addr_b), .mem_we(we_b), .mem_wd(wd_b), .mem_rd(rd_b)
    );

`ifndef IMEM_LOADER_CHECKSUM_EN
    assign csum_a = '0;
    assign csum_b = '0;
`endif

    always @(posedge clk) begin
        if (we_a) begin
            ram_a[addr_a] <= wd_a;
            wr_a <= wr_a + 1;
        end
        if (we_b) begin
            ram_b[addr_b] <= wd_b;
            wr_b <= wr_b + 1;
        end
    end
    assign rd_a = ram_a[addr_a];
    assign rd_b = ram_b[addr_b];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_t;

    fetch_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit b);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        bsum = '0;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input bit b, input logic [7:0] d, input bit last);
        int   n;
        logic r;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        forever begin
            r = b ? ready_b : ready_a;
            step();
            if (r) begin
                bsum = bsum + d;
                break;
            end
            n++;
            if (n > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got no ld_ready expected accept");
                break;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_done(input bit b);
        int n;
        n = 0;
        while (!(b ? done_b : done_a)) begin
            step();
            n++;
            if (n > 30) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout: got no ld_done expected pulse");
                return;
            end
        end
    endtask

    function automatic logic exp_err(input logic ovf);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return ovf || (bsum != 8'd0);
`else
        return ovf;
`endif
    endfunction

    task automatic load_a(input logic [7:0] bytes [], input int cnt);
        start(1'b0);
        for (int i = 0; i < cnt; i++) begin
            send(1'b0, bytes[i], i == cnt - 1);
        end
        wait_done(1'b0);
    endtask

    initial begin
        logic [7:0] p1 [];
        logic [7:0] p2 [];
        logic [7:0] p3 [];
        int         w0;

        step();
        step();
        chk("rst_hold", hold_a, 0);
        chk("rst_cpu_rst", rst_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", error_a, 0);
        chk("rst_words", words_a, 0);
        chk("rst_we", we_a, 0);
        reset = 1'b0;
        step();

        // Test 1: two full words, then fetch table.
        start(1'b0);
        chk("collect_hold", hold_a, 1);
        chk("collect_ready", ready_a, 1);
        chk("collect_nop", instr_a, NOP);
        p1 = '{8'h78, 8'h00, 8'hA0, 8'hE3, 8'h4B, 8'h1E, 8'hA0, 8'hE3};
        for (int i = 0; i < 8; i++) begin
            send(1'b0, p1[i], i == 7);
        end
        wait_done(1'b0);
        chk("t1_done", done_a, 1);
        chk("t1_cpu_rst", rst_a, 1);
        chk("t1_done_hold", hold_a, 1);
        step();
        chk("t1_done_off", done_a, 0);
        chk("t1_cpu_rst_off", rst_a, 0);
        chk("t1_hold_off", hold_a, 0);
        chk("t1_words", words_a, 2);
        chk("t1_error", error_a, exp_err(1'b0));
        chk("t1_w0", ram_a[0], 32'hE3A00078);
        chk("t1_w1", ram_a[1], 32'hE3A01E4B);

        tbl[0] = '{32'h0000_0000, 32'hE3A00078};
        tbl[1] = '{32'h0000_0004, 32'hE3A01E4B};
        tbl[2] = '{32'h0000_0007, 32'hE3A01E4B};
        tbl[3] = '{32'h0000_0005, 32'hE3A01E4B};
        tbl[4] = '{32'h0000_0003, 32'hE3A00078};
        tbl[5] = '{32'h0000_0200, NOP};
        tbl[6] = '{32'h8000_0004, NOP};
        for (int i = 0; i < 7; i++) begin
            cpu_addr = tbl[i].addr;
            #1;
            chk($sformatf("fetch_%0d", i), instr_a, tbl[i].instr);
            chk($sformatf("fetch_hold_%0d", i), hold_a, 0);
        end
        cpu_addr = '0;

        // Test 2: partial final word is zero-filled.
        p2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_a(p2, 5);
        step();
        chk("t2_w0", ram_a[0], 32'h04030201);
        chk("t2_w1", ram_a[1], 32'h00000005);
        chk("t2_words", words_a, 2);
        chk("t2_error", error_a, exp_err(1'b0));

        // Last on a 4th byte: exactly one write.
        w0 = wr_a;
        p3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_a(p3, 4);
        step();
        chk("last4_writes", wr_a - w0, 1);
        chk("last4_words", words_a, 1);
        chk("last4_w0", ram_a[0], 32'h44332211);

        // ld_start during COLLECT must not restart packing.
        start(1'b0);
        send(1'b0, 8'hAA, 1'b0);
        send(1'b0, 8'hBB, 1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("restart_hold", hold_a, 1);
        send(1'b0, 8'hCC, 1'b0);
        send(1'b0, 8'hDD, 1'b0);
        send(1'b0, 8'hEE, 1'b1);
        wait_done(1'b0);
        step();
        chk("restart_w0", ram_a[0], 32'hDDCCBBAA);
        chk("restart_w1", ram_a[1], 32'h000000EE);
        chk("restart_words", words_a, 2);

        // Reset in the middle of COLLECT.
        start(1'b0);
        send(1'b0, 8'h55, 1'b0);
        send(1'b0, 8'h66, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_hold", hold_a, 0);
        chk("midrst_ready", ready_a, 0);
        chk("midrst_we", we_a, 0);
        chk("midrst_done", done_a, 0);
        cpu_addr = 32'h0;
        #1;
        chk("midrst_fetch", instr_a, 32'hDDCCBBAA);
        step();

        // Test 3: DEPTH=4 overflow then drain.
        w0 = wr_b;
        start(1'b1);
        for (int i = 1; i <= 20; i++) begin
            send(1'b1, 8'(i), i == 20);
        end
        wait_done(1'b1);
        step();
        chk("ovf_error", error_b, 1);
        chk("ovf_words", words_b, 4);
        chk("ovf_writes", wr_b - w0, 4);
        chk("ovf_w0", ram_b[0], 32'h04030201);
        chk("ovf_w1", ram_b[1], 32'h08070605);
        chk("ovf_w2", ram_b[2], 32'h0C0B0A09);
        chk("ovf_w3", ram_b[3], 32'h100F0E0D);
        chk("ovf_hold", hold_b, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        p3 = '{8'h01, 8'h02, 8'hFD, 8'h00};
        load_a(p3, 3);
        step();
        chk("csum_ok_error", error_a, 0);
        chk("csum_ok_sum", csum_a, 8'h00);
        chk("csum_ok_w0", ram_a[0], 32'h00FD0201);
        p3 = '{8'h01, 8'h02, 8'hFC, 8'h00};
        load_a(p3, 3);
        step();
        chk("csum_bad_error", error_a, 1);
        chk("csum_bad_sum", csum_a, 8'hFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
